// File: rtl/bin_to_bcd_dabble.sv
// Sequential double-dabble binary-to-BCD converter: one shift per clock, saturating overflow, significant-digit count.
// Optional BCD_SIGNED_EN: two's complement input, magnitude converted and sign reported on sign_o.
module bin_to_bcd_dabble #(
  parameter int BIN_N  = 16,
  parameter int DIGITS = 5
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic [BIN_N-1:0]                  binary_i,
  output logic                              ready_o,
  output logic                              done_o,
  output logic [4*DIGITS-1:0]               bcd_o,
  output logic [$clog2(DIGITS+1)-1:0]       ndigits_o,
  output logic                              overflow_o
`ifdef BCD_SIGNED_EN
  ,
  output logic                              sign_o
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int NDW   = $clog2(DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_N);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   scratch_bcd;
  logic [BIN_N-1:0]   operand;
  logic               ovf_acc;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   adj_bcd;
  logic [BCD_W-1:0]   shift_bcd;
  logic               shift_ovf;
  logic [NDW-1:0]     sig_digits;
  logic [BIN_N-1:0]   magnitude;

`ifdef BCD_SIGNED_EN
  logic               sign_acc;
  logic               capture_neg;

  // The most negative input negates to itself, which still reads correctly as an unsigned magnitude.
  assign capture_neg = binary_i[BIN_N-1];
  assign magnitude   = capture_neg ? -binary_i : binary_i;
`else
  assign magnitude   = binary_i;
`endif

  always_comb begin
    adj_bcd = scratch_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_bcd[4*i +: 4] >= 4'd5) begin
        adj_bcd[4*i +: 4] = scratch_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Any bit shifted out of the top digit means the value needs more digits than we have.
  assign shift_bcd = {adj_bcd[BCD_W-2:0], operand[BIN_N-1]};
  assign shift_ovf = ovf_acc | adj_bcd[BCD_W-1];

  always_comb begin
    sig_digits = NDW'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (shift_bcd[4*i +: 4] != 4'd0) begin
        sig_digits = NDW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      done_o      <= 1'b0;
      bcd_o       <= '0;
      ndigits_o   <= NDW'(1);
      overflow_o  <= 1'b0;
      cnt         <= '0;
      scratch_bcd <= '0;
      operand     <= '0;
      ovf_acc     <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_acc    <= 1'b0;
      sign_o      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            operand     <= magnitude;
            scratch_bcd <= '0;
            ovf_acc     <= 1'b0;
            cnt         <= CNT_W'(BIN_N - 1);
            ready_o     <= 1'b0;
            state       <= SHIFT;
`ifdef BCD_SIGNED_EN
            sign_acc    <= capture_neg;
`endif
          end
        end
        SHIFT: begin
          scratch_bcd <= shift_bcd;
          operand     <= {operand[BIN_N-2:0], 1'b0};
          ovf_acc     <= shift_ovf;
          if (cnt == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
            if (shift_ovf) begin
              bcd_o      <= {DIGITS{4'h9}};
              ndigits_o  <= NDW'(DIGITS);
              overflow_o <= 1'b1;
            end else begin
              bcd_o      <= shift_bcd;
              ndigits_o  <= sig_digits;
              overflow_o <= 1'b0;
            end
`ifdef BCD_SIGNED_EN
            sign_o <= sign_acc;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_dabble.sv
// Directed testbench for bin_to_bcd_dabble: a 5-digit and a 4-digit instance share clock, reset and stimulus.
// Signed cases are exercised only when BCD_SIGNED_EN is defined.
module tb_bin_to_bcd_dabble;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] binary;

  logic        ready5, done5, ovf5;
  logic [19:0] bcd5;
  logic [2:0]  nd5;
  logic        ready4, done4, ovf4;
  logic [15:0] bcd4;
  logic [2:0]  nd4;
`ifdef BCD_SIGNED_EN
  logic        sign5, sign4;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bin_to_bcd_dabble #(.BIN_N(16), .DIGITS(5)) dut5 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .binary_i(binary),
    .ready_o(ready5), .done_o(done5), .bcd_o(bcd5), .ndigits_o(nd5), .overflow_o(ovf5)
`ifdef BCD_SIGNED_EN
    , .sign_o(sign5)
`endif
  );

  bin_to_bcd_dabble #(.BIN_N(16), .DIGITS(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .binary_i(binary),
    .ready_o(ready4), .done_o(done4), .bcd_o(bcd4), .ndigits_o(nd4), .overflow_o(ovf4)
`ifdef BCD_SIGNED_EN
    , .sign_o(sign4)
`endif
  );

  // Reference conversion by repeated division, independent of the shift-and-add algorithm.
  function automatic logic [19:0] model_bcd(input int v);
    logic [19:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] model_nd(input int v);
    int n;
    int t;
    n = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return 3'(n);
  endfunction

  task automatic convert(input logic [15:0] value, input bit disturb, output int lat);
    @(posedge clk); #1;
    start  = 1'b1;
    binary = value;
    @(posedge clk); #1;
    start  = 1'b0;
    binary = ~value;
    lat    = 0;
    while (done5 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat < 11) begin
        start  = lat[0];
        binary = binary ^ 16'h5a5a;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready5 !== 1'b1) $display("[TB] FAIL reset_ready: got %0b want 1", ready5); else passes++;
    checks++; if (done5 !== 1'b0) $display("[TB] FAIL reset_done: got %0b want 0", done5); else passes++;
    checks++; if (bcd5 !== 20'h0) $display("[TB] FAIL reset_bcd: got %h want 00000", bcd5); else passes++;
    checks++; if (nd5 !== 3'd1) $display("[TB] FAIL reset_ndigits: got %0d want 1", nd5); else passes++;
    checks++; if (ovf5 !== 1'b0) $display("[TB] FAIL reset_overflow: got %0b want 0", ovf5); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    convert(16'd0, 1'b0, lat);
    checks++; if (lat !== 16) $display("[TB] FAIL zero_latency: got %0d want 16", lat); else passes++;
    checks++; if (bcd5 !== 20'h00000) $display("[TB] FAIL zero_bcd: got %h want 00000", bcd5); else passes++;
    checks++; if (nd5 !== 3'd1) $display("[TB] FAIL zero_ndigits: got %0d want 1", nd5); else passes++;
    checks++; if (ovf5 !== 1'b0) $display("[TB] FAIL zero_overflow: got %0b want 0", ovf5); else passes++;
    @(posedge clk); #1;
    checks++; if (ready5 !== 1'b1) $display("[TB] FAIL zero_ready_after: got %0b want 1", ready5); else passes++;
    checks++; if (done5 !== 1'b0) $display("[TB] FAIL zero_done_pulse: got %0b want 0", done5); else passes++;
  endtask

  task automatic test_max();
    int lat;
    convert(16'd65535, 1'b0, lat);
    checks++; if (lat !== 16) $display("[TB] FAIL max_latency: got %0d want 16", lat); else passes++;
    checks++; if (bcd5 !== 20'h65535) $display("[TB] FAIL max_bcd: got %h want 65535", bcd5); else passes++;
    checks++; if (nd5 !== 3'd5) $display("[TB] FAIL max_ndigits: got %0d want 5", nd5); else passes++;
    checks++; if (ovf5 !== 1'b0) $display("[TB] FAIL max_overflow: got %0b want 0", ovf5); else passes++;
    checks++; if (bcd4 !== 16'h9999) $display("[TB] FAIL max_bcd4: got %h want 9999", bcd4); else passes++;
    checks++; if (ovf4 !== 1'b1) $display("[TB] FAIL max_overflow4: got %0b want 1", ovf4); else passes++;
  endtask

  task automatic test_overflow();
    int lat;
    convert(16'd12345, 1'b0, lat);
    checks++; if (bcd4 !== 16'h9999) $display("[TB] FAIL ovf_bcd4: got %h want 9999", bcd4); else passes++;
    checks++; if (ovf4 !== 1'b1) $display("[TB] FAIL ovf_flag4: got %0b want 1", ovf4); else passes++;
    checks++; if (nd4 !== 3'd4) $display("[TB] FAIL ovf_ndigits4: got %0d want 4", nd4); else passes++;
    checks++; if (bcd5 !== 20'h12345) $display("[TB] FAIL ovf_bcd5: got %h want 12345", bcd5); else passes++;
    convert(16'd9999, 1'b0, lat);
    checks++; if (bcd4 !== 16'h9999) $display("[TB] FAIL edge_bcd4: got %h want 9999", bcd4); else passes++;
    checks++; if (ovf4 !== 1'b0) $display("[TB] FAIL edge_flag4: got %0b want 0", ovf4); else passes++;
    checks++; if (nd4 !== 3'd4) $display("[TB] FAIL edge_ndigits4: got %0d want 4", nd4); else passes++;
    convert(16'd10000, 1'b0, lat);
    checks++; if (ovf4 !== 1'b1) $display("[TB] FAIL tenk_flag4: got %0b want 1", ovf4); else passes++;
    checks++; if (bcd5 !== 20'h10000) $display("[TB] FAIL tenk_bcd5: got %h want 10000", bcd5); else passes++;
    checks++; if (nd5 !== 3'd5) $display("[TB] FAIL tenk_ndigits5: got %0d want 5", nd5); else passes++;
    convert(16'd90, 1'b0, lat);
    checks++; if (bcd5 !== 20'h00090) $display("[TB] FAIL ninety_bcd5: got %h want 00090", bcd5); else passes++;
    checks++; if (nd5 !== 3'd2) $display("[TB] FAIL ninety_ndigits5: got %0d want 2", nd5); else passes++;
  endtask

  task automatic test_back_to_back();
    int          val;
    int          dones;
    int          cyc;
    int          last_done;
    logic [15:0] expv;
    val       = 1;
    dones     = 0;
    cyc       = 0;
    last_done = -1;
    @(posedge clk); #1;
    start  = 1'b1;
    binary = 16'd0;
    expv   = 16'd0;
    while (dones < 1024 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (done5 === 1'b1) begin
        checks++;
        if (bcd5 !== model_bcd(int'(expv))) $display("[TB] FAIL sweep_bcd value %0d: got %h want %h", expv, bcd5, model_bcd(int'(expv)));
        else passes++;
        checks++;
        if (nd5 !== model_nd(int'(expv))) $display("[TB] FAIL sweep_ndigits value %0d: got %0d want %0d", expv, nd5, model_nd(int'(expv)));
        else passes++;
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== 18) $display("[TB] FAIL sweep_gap value %0d: got %0d want 18", expv, cyc - last_done);
          else passes++;
        end
        last_done = cyc;
        dones++;
        if (dones == 1024) start = 1'b0;
      end else if (ready5 === 1'b1) begin
        binary = val[15:0];
        expv   = val[15:0];
        val++;
      end
    end
    start = 1'b0;
    checks++; if (dones !== 1024) $display("[TB] FAIL sweep_done_count: got %0d want 1024", dones); else passes++;
  endtask

  task automatic test_ignore();
    int lat;
    convert(16'd4321, 1'b1, lat);
    checks++; if (lat !== 16) $display("[TB] FAIL ignore_latency: got %0d want 16", lat); else passes++;
    checks++; if (bcd5 !== 20'h04321) $display("[TB] FAIL ignore_bcd: got %h want 04321", bcd5); else passes++;
    checks++; if (nd5 !== 3'd4) $display("[TB] FAIL ignore_ndigits: got %0d want 4", nd5); else passes++;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    binary = 16'd777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++; if (ready5 !== 1'b1) $display("[TB] FAIL midreset_ready: got %0b want 1", ready5); else passes++;
    checks++; if (done5 !== 1'b0) $display("[TB] FAIL midreset_done: got %0b want 0", done5); else passes++;
    checks++; if (bcd5 !== 20'h0) $display("[TB] FAIL midreset_bcd: got %h want 00000", bcd5); else passes++;
    checks++; if (nd5 !== 3'd1) $display("[TB] FAIL midreset_ndigits: got %0d want 1", nd5); else passes++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done5 === 1'b1) dones++;
    end
    checks++; if (dones !== 0) $display("[TB] FAIL midreset_no_done: got %0d want 0", dones); else passes++;
    checks++; if (ready5 !== 1'b1) $display("[TB] FAIL midreset_idle: got %0b want 1", ready5); else passes++;
  endtask

`ifdef BCD_SIGNED_EN
  task automatic test_signed();
    int lat;
    convert(16'h8000, 1'b0, lat);
    checks++; if (sign5 !== 1'b1) $display("[TB] FAIL neg_min_sign: got %0b want 1", sign5); else passes++;
    checks++; if (bcd5 !== 20'h32768) $display("[TB] FAIL neg_min_bcd: got %h want 32768", bcd5); else passes++;
    checks++; if (lat !== 16) $display("[TB] FAIL neg_min_latency: got %0d want 16", lat); else passes++;
    convert(16'hFFFF, 1'b0, lat);
    checks++; if (sign5 !== 1'b1) $display("[TB] FAIL neg_one_sign: got %0b want 1", sign5); else passes++;
    checks++; if (bcd5 !== 20'h00001) $display("[TB] FAIL neg_one_bcd: got %h want 00001", bcd5); else passes++;
    checks++; if (nd5 !== 3'd1) $display("[TB] FAIL neg_one_ndigits: got %0d want 1", nd5); else passes++;
    convert(16'h7FFF, 1'b0, lat);
    checks++; if (sign5 !== 1'b0) $display("[TB] FAIL pos_max_sign: got %0b want 0", sign5); else passes++;
    checks++; if (bcd5 !== 20'h32767) $display("[TB] FAIL pos_max_bcd: got %h want 32767", bcd5); else passes++;
    convert(16'h0000, 1'b0, lat);
    checks++; if (sign5 !== 1'b0) $display("[TB] FAIL zero_sign: got %0b want 0", sign5); else passes++;
    checks++; if (bcd5 !== 20'h00000) $display("[TB] FAIL signed_zero_bcd: got %h want 00000", bcd5); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
`ifndef BCD_SIGNED_EN
    test_max();
`endif
    test_overflow();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
`ifdef BCD_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
